inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage: the producer side of the pc/inst pair consumed by the decode stage through if_id.
//  Reads 32-bit instructions little-endian, one byte per cycle, from a byte-wide memory port and holds each
//  complete instruction until downstream accepts it.
//  Takes the decode-stage redirect (jump_flag/jump_addr) and restarts fetch at the target, discarding in-flight data.
// PARAMETERS
//  ADDR_W    32   address / pc width
//  INST_W    32   instruction width (fixed 4 bytes)
//  RESET_PC  0    first fetch address after reset
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  rst           in   1       reset, synchronous, active-high
//  stall_i       in   1       downstream cannot accept the held instruction this cycle
//  jump_flag_i   in   1       redirect request from decode
//  jump_addr_i   in   ADDR_W  redirect target
//  mem_rd_o      out  1       byte read request
//  mem_addr_o    out  ADDR_W  byte address of request
//  mem_gnt_i     in   1       request accepted this cycle
//  mem_din_i     in   8       read data, valid exactly 1 cycle after a granted request
//  pc_o          out  ADDR_W  address of held instruction
//  inst_o        out  INST_W  held instruction
//  inst_valid_o  out  1       pc_o/inst_o hold a complete instruction
// BEHAVIOUR
//  Reset (rst=1 at edge):
//  - state=FETCH, fetch_pc=RESET_PC, req_cnt=rcv_cnt=0, discard=0.
//  - pc_o=RESET_PC, inst_o=0, inst_valid_o=0.
//  - mem_rd_o=0 while rst high.
//  Reset mid-fetch abandons all progress; no grant is possible during reset, so no stale byte follows.
//  Outputs:
//  - mem_rd_o = !rst & state==FETCH & req_cnt<4 (combinational).
//  - mem_addr_o = fetch_pc + req_cnt, modulo 2^ADDR_W.
//  - pc_o, inst_o, inst_valid_o are registered.
//  FETCH:
//  - A cycle with mem_rd_o & mem_gnt_i increments req_cnt; ungranted cycles hold mem_addr_o unchanged.
//  - Cycle after each grant (and discard=0): mem_din_i -> inst_buf[8*rcv_cnt +: 8], rcv_cnt++.
//  - When the 4th byte is captured: state->HOLD, inst_valid_o=1, inst_o=assembled word, pc_o=fetch_pc,
//    all visible the next cycle.
//  HOLD:
//  - mem_rd_o=0; outputs stable.
//  - Accept = inst_valid_o & !stall_i & !jump_flag_i. On accept: fetch_pc += 4 (wraps 0xFFFFFFFC->0),
//    counters cleared, state->FETCH, inst_valid_o=0 next cycle.
//  Redirect (any state, highest priority over stall and accept):
//  - fetch_pc<=jump_addr_i, used unaligned as given; counters cleared; state->FETCH; inst_valid_o<=0.
//  - If a grant occurs in the jump cycle, discard<=1 and the byte returned next cycle is ignored.
//  - A byte arriving in the jump cycle itself is ignored.
//  - The instruction presented in the jump cycle is not accepted.
//  - Fetch at the target may issue in the cycle after the jump.
//  discard clears after one cycle.
//  Latency with gnt stuck at 1: requests in cycles 0..3 after reset release, inst_valid_o high in cycle 5.
//  Throughput: one instruction per 6 cycles when unstalled.
// TESTING
//  1. gnt=1, mem[0..3]=13 05 A0 00, release reset
//     -> inst_valid_o=1 in cycle 5, inst_o=0x00A00513, pc_o=0x0; next mem_addr_o=0x4 after accept.
//  2. Hold stall_i=1 for 3 cycles while valid
//     -> pc_o/inst_o/inst_valid_o unchanged, mem_rd_o=0; drop stall -> next request to 0x4.
//  3. gnt pattern 1,0,1,0,1,0,1
//     -> mem_addr_o held during ungranted cycles, bytes 0..3 assembled correctly, same inst_o as test 1.
//  4. After 2 bytes captured, jump_flag_i=1, jump_addr_i=0x100, gnt=1 in jump cycle
//     -> next byte discarded, no valid for the old fetch, next inst_o = word at 0x100, pc_o=0x100.
//  5. jump_flag_i=1 while HOLD with stall_i=1
//     -> inst_valid_o=0 next cycle, fetch restarts at jump_addr_i.
//  6. Accept at pc_o=0xFFFFFFFC -> next mem_addr_o=0x00000000.
//     rst pulsed mid-fetch -> outputs at reset values, refetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Groups the bus signals around the instruction fetch stage. The signals use
// the fetch stage's _i/_o suffixes, so the names read from the fetch side.
//   Redirect / flow control (into fetch):
//     stall_i      downstream cannot accept the held instruction this cycle
//     jump_flag_i  redirect request from decode
//     jump_addr_i  redirect target
//   Byte-wide memory port:
//     mem_rd_o     byte read request            (fetch -> memory)
//     mem_addr_o   byte address of the request  (fetch -> memory)
//     mem_gnt_i    request accepted this cycle  (memory -> fetch)
//     mem_din_i    read data, one cycle after a granted request
//   Fetch -> decode:
//     pc_o         address of the held instruction
//     inst_o       held instruction
//     inst_valid_o pc_o/inst_o hold a complete instruction
// Modports:
//   master - the fetch stage
//   slave  - the environment around it (memory, decode, hazard logic)
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              stall_i;
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic [7:0]        mem_din_i;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              inst_valid_o;

    modport master (
        input  stall_i,
        input  jump_flag_i,
        input  jump_addr_i,
        input  mem_gnt_i,
        input  mem_din_i,
        output mem_rd_o,
        output mem_addr_o,
        output pc_o,
        output inst_o,
        output inst_valid_o
    );

    modport slave (
        output stall_i,
        output jump_flag_i,
        output jump_addr_i,
        output mem_gnt_i,
        output mem_din_i,
        input  mem_rd_o,
        input  mem_addr_o,
        input  pc_o,
        input  inst_o,
        input  inst_valid_o
    );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. It reads 32-bit instructions little-endian, one
// byte per cycle, from a byte-wide memory port. It holds each complete
// instruction on pc_o/inst_o/inst_valid_o until decode accepts it. A decode
// redirect (jump_flag_i/jump_addr_i) restarts fetch at the target and drops
// any data still in flight.
// Ports:
//   clk   clock; all state updates on the rising edge
//   rst   synchronous, active-high reset
//   bus   inst_fetch_if.master: redirect/stall inputs, byte memory port,
//         and the registered pc/inst/valid outputs towards decode
// Parameters:
//   ADDR_W    address / pc width
//   INST_W    instruction width (always 4 bytes)
//   RESET_PC  first fetch address after reset
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Architectural state
    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
    logic [2:0]        req_cnt_q,    req_cnt_d;     // bytes requested: 0..4
    logic [1:0]        rcv_cnt_q,    rcv_cnt_d;     // bytes captured:  0..3
    logic              rsp_pend_q,   rsp_pend_d;    // a byte returns this cycle
    logic              discard_q,    discard_d;     // returning byte belongs to a dropped fetch
    logic [INST_W-1:0] inst_buf_q,   inst_buf_d;
    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic [INST_W-1:0] inst_q,       inst_d;
    logic              inst_valid_q, inst_valid_d;

    // Per-cycle decode of the current situation
    logic              mem_rd_s;
    logic              grant_s;
    logic              jump_s;
    logic              capture_s;
    logic              last_byte_s;
    logic              accept_s;
    logic [INST_W-1:0] word_s;

    // Request, capture and accept conditions for this cycle
    always_comb begin
        mem_rd_s    = (!rst) && (state_q == ST_FETCH) && (req_cnt_q < 3'd4);
        grant_s     = mem_rd_s && bus.mem_gnt_i;
        jump_s      = bus.jump_flag_i;
        // A byte is taken only if it answers a request of the fetch that is
        // still live. A byte arriving in a redirect cycle is stale by definition.
        capture_s   = rsp_pend_q && (!discard_q) && (!jump_s) && (state_q == ST_FETCH);
        last_byte_s = capture_s && (rcv_cnt_q == 2'd3);
        accept_s    = inst_valid_q && (!bus.stall_i) && (!jump_s);
        // Buffer with the returning byte merged in. On the last byte this is
        // the complete little-endian instruction.
        word_s      = inst_buf_q;
        if (capture_s) begin
            word_s[{rcv_cnt_q, 3'b000} +: 8] = bus.mem_din_i;
        end else begin
            word_s = inst_buf_q;
        end
    end

    // Next-state computation for the fetch FSM and its datapath
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_cnt_d    = req_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        inst_buf_d   = inst_buf_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        // The memory answers exactly one cycle after a grant. discard covers
        // only that single follow-up cycle.
        rsp_pend_d   = grant_s;
        discard_d    = 1'b0;

        if (jump_s) begin
            // Redirect wins over stall and accept in every state. The target
            // is used as given, even when unaligned.
            state_d      = ST_FETCH;
            fetch_pc_d   = bus.jump_addr_i;
            req_cnt_d    = 3'd0;
            rcv_cnt_d    = 2'd0;
            inst_valid_d = 1'b0;
            discard_d    = grant_s;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (grant_s) begin
                        req_cnt_d = req_cnt_q + 3'd1;
                    end else begin
                        req_cnt_d = req_cnt_q;
                    end
                    if (last_byte_s) begin
                        state_d      = ST_HOLD;
                        inst_buf_d   = word_s;
                        inst_d       = word_s;
                        pc_d         = fetch_pc_q;
                        inst_valid_d = 1'b1;
                        rcv_cnt_d    = 2'd0;
                    end else if (capture_s) begin
                        inst_buf_d   = word_s;
                        rcv_cnt_d    = rcv_cnt_q + 2'd1;
                    end else begin
                        inst_buf_d   = inst_buf_q;
                        rcv_cnt_d    = rcv_cnt_q;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        // The pc wraps naturally at the top of the address space.
                        state_d      = ST_FETCH;
                        fetch_pc_d   = fetch_pc_q + ADDR_W'(3'd4);
                        req_cnt_d    = 3'd0;
                        rcv_cnt_d    = 2'd0;
                        inst_valid_d = 1'b0;
                    end else begin
                        state_d      = ST_HOLD;
                        fetch_pc_d   = fetch_pc_q;
                        inst_valid_d = inst_valid_q;
                    end
                end
                default: begin
                    // Unreachable encoding: restart cleanly at the current pc.
                    state_d      = ST_FETCH;
                    req_cnt_d    = 3'd0;
                    rcv_cnt_d    = 2'd0;
                    inst_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= RESET_PC;
            req_cnt_q    <= 3'd0;
            rcv_cnt_q    <= 2'd0;
            rsp_pend_q   <= 1'b0;
            discard_q    <= 1'b0;
            inst_buf_q   <= '0;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_cnt_q    <= req_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            rsp_pend_q   <= rsp_pend_d;
            discard_q    <= discard_d;
            inst_buf_q   <= inst_buf_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign bus.mem_rd_o     = mem_rd_s;
    assign bus.mem_addr_o   = fetch_pc_q + ADDR_W'(req_cnt_q);
    assign bus.pc_o         = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. The stimulus pushes the expected (pc, inst)
// for each instruction that should reach decode. A separate monitor pops and
// compares whenever inst_valid_o rises. A byte memory model answers granted
// reads one cycle later and drives a poison byte otherwise.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

    inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: two fixed words at 0 and 4, a simple address hash elsewhere
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: mem_byte = 8'h13;
            32'h1: mem_byte = 8'h05;
            32'h2: mem_byte = 8'hA0;
            32'h3: mem_byte = 8'h00;
            32'h4: mem_byte = 8'h33;
            32'h5: mem_byte = 8'h06;
            32'h6: mem_byte = 8'hB5;
            32'h7: mem_byte = 8'h00;
            default: mem_byte = a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    // Byte memory: data one cycle after a granted request, poison otherwise
    always @(posedge clk) begin
        if (bus.mem_rd_o === 1'b1 && bus.mem_gnt_i === 1'b1) begin
            bus.mem_din_i <= mem_byte(bus.mem_addr_o);
        end else begin
            bus.mem_din_i <= 8'hEE;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb_q.push_back(e);
    endtask

    // Advance until the DUT requests address a (sampled mid-cycle), bounded
    task automatic wait_addr(input logic [31:0] a);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (bus.mem_rd_o === 1'b1 && bus.mem_addr_o === a) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_addr timeout actual=%h required=%h", bus.mem_addr_o, a);
        end
    endtask

    // Advance until inst_valid_o is high (sampled mid-cycle), bounded
    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (bus.inst_valid_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s valid timeout actual=0 required=1", name);
        end
    endtask

    // Monitor: compare each newly presented instruction against the scoreboard
    initial begin
        bit   prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (bus.inst_valid_o === 1'b1 && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual pc=%h inst=%h required none",
                             bus.pc_o, bus.inst_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", bus.pc_o, e.pc);
                    chk("sb_inst", bus.inst_o, e.inst);
                end
            end
            prev_valid = (bus.inst_valid_o === 1'b1);
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[7];
        int grants;
        pat = '{1, 0, 1, 0, 1, 0, 1};
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall_i     = 1'b1;
        bus.jump_flag_i = 1'b0;
        bus.jump_addr_i = 32'h0;
        bus.mem_gnt_i   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_inst", bus.inst_o, 32'h0);

        // Test 1: gnt stuck at 1, requests in cycles 0..3, valid in cycle 5
        push_exp(32'h0, 32'h00A00513);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1_rd_c0", 32'(bus.mem_rd_o), 32'd1);
        chk("t1_addr_c0", bus.mem_addr_o, 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("t1_rd", 32'(bus.mem_rd_o), 32'd1);
            chk("t1_addr", bus.mem_addr_o, 32'(i));
        end
        @(negedge clk);
        #1;
        chk("t1_rd_c4", 32'(bus.mem_rd_o), 32'd0);
        chk("t1_valid_c4", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        #1;
        chk("t1_valid_c5", 32'(bus.inst_valid_o), 32'd1);
        chk("t1_inst", bus.inst_o, 32'h00A00513);
        chk("t1_pc", bus.pc_o, 32'h0);

        // Test 2: stalled hold keeps outputs stable with no requests
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("t2_valid", 32'(bus.inst_valid_o), 32'd1);
            chk("t2_pc", bus.pc_o, 32'h0);
            chk("t2_inst", bus.inst_o, 32'h00A00513);
            chk("t2_rd", 32'(bus.mem_rd_o), 32'd0);
        end
        @(negedge clk);
        bus.stall_i = 1'b0;
        push_exp(32'h4, 32'h00B50633);

        // Test 3: gnt 1,0,1,0,1,0,1; address holds while ungranted
        grants = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.mem_gnt_i = pat[k][0];
            #1;
            chk("t3_rd", 32'(bus.mem_rd_o), 32'd1);
            chk("t3_addr", bus.mem_addr_o, 32'h4 + 32'(grants));
            grants += pat[k];
        end
        @(negedge clk);
        bus.mem_gnt_i = 1'b1;

        // Test 4: redirect after two bytes captured, with a grant in the jump cycle
        wait_addr(32'h8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'h100;
        bus.stall_i     = 1'b1;
        #1;
        chk("t4_addr_jump_cycle", bus.mem_addr_o, 32'hB);
        push_exp(32'h100, 32'h3E3F3C3D);
        @(negedge clk);
        bus.jump_flag_i = 1'b0;
        #1;
        chk("t4_rd_target", 32'(bus.mem_rd_o), 32'd1);
        chk("t4_addr_target", bus.mem_addr_o, 32'h100);
        chk("t4_valid", 32'(bus.inst_valid_o), 32'd0);

        // Test 5: redirect while holding under stall
        wait_valid("t5_hold");
        @(negedge clk);
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'h200;
        #1;
        chk("t5_valid_in_jump", 32'(bus.inst_valid_o), 32'd1);
        push_exp(32'h200, 32'h3D3C3F3E);
        @(negedge clk);
        bus.jump_flag_i = 1'b0;
        bus.stall_i     = 1'b0;
        #1;
        chk("t5_valid_after", 32'(bus.inst_valid_o), 32'd0);
        chk("t5_addr", bus.mem_addr_o, 32'h200);
        chk("t5_rd", 32'(bus.mem_rd_o), 32'd1);

        // Test 6: accept at the top of the address space wraps to 0
        wait_valid("t6_200");
        @(negedge clk);
        #1;
        chk("t6_next_addr", bus.mem_addr_o, 32'h204);
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC, 32'h3C3D3E3F);
        @(negedge clk);
        bus.jump_flag_i = 1'b0;
        #1;
        chk("t6_addr_top", bus.mem_addr_o, 32'hFFFF_FFFC);
        wait_valid("t6_top");
        @(negedge clk);
        #1;
        chk("t6_wrap_addr", bus.mem_addr_o, 32'h0);
        chk("t6_wrap_rd", 32'(bus.mem_rd_o), 32'd1);
        chk("t6_wrap_valid", 32'(bus.inst_valid_o), 32'd0);

        // Reset pulsed mid-fetch
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_rd", 32'(bus.mem_rd_o), 32'd0);
        @(negedge clk);
        #1;
        chk("rst2_pc", bus.pc_o, 32'h0);
        chk("rst2_inst", bus.inst_o, 32'h0);
        chk("rst2_valid", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(32'h0, 32'h00A00513);
        #1;
        chk("rst2_refetch_addr", bus.mem_addr_o, 32'h0);
        chk("rst2_refetch_rd", 32'(bus.mem_rd_o), 32'd1);
        wait_valid("rst2_refetch");

        repeat (3) @(negedge clk);
        #3;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
